// File: rtl/key_debounce_pkg.sv
// Shared constants for the key debouncer.
// The level constants state which raw pin level means "pressed" and which means "released".
package key_debounce_pkg;

  // 20 ms settling window at 50 MHz.
  localparam int CNT_MAX_DEFAULT = 1_000_000;

  // Board keys pull the pin low when pressed.
  localparam bit KEY_ACTIVE_LOW_DEFAULT = 1'b1;

  // Raw pin levels for the board-default polarity.
  localparam logic KEY_RELEASED = KEY_ACTIVE_LOW_DEFAULT ? 1'b1 : 1'b0;
  localparam logic KEY_PRESSED  = ~KEY_RELEASED;

  // Raw pin level that means "released" for a given polarity.
  function automatic logic released_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for the asynchronous key pin.
// The reset value is a parameter, so a key that is idle at reset is not seen as a change.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  // Shift the raw pin through two flops; only the second flop is used downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronise, filter bounce, and emit one key_pulse per accepted press.
// Optional feature: define KEY_DEBOUNCE_LEVEL_EN to add the key_level output
// (debounced level, 1 = pressed).
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int CNT_MAX        = CNT_MAX_DEFAULT,
  parameter bit KEY_ACTIVE_LOW = KEY_ACTIVE_LOW_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_pulse
`ifdef KEY_DEBOUNCE_LEVEL_EN
  ,
  output logic key_level
`endif
);

  localparam logic REL_LVL   = released_level(KEY_ACTIVE_LOW);
  localparam logic PRESS_LVL = ~REL_LVL;
  localparam int   CW        = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic          key_sync;
  logic          stable;
  logic [CW-1:0] cnt;

  sync_2ff #(
    .RESET_VAL(REL_LVL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (key),
    .q  (key_sync)
  );

  // Count consecutive samples that differ from the accepted level. Any sample that matches the
  // accepted level restarts the count. A full run moves the accepted level. key_pulse fires on
  // the same edge when the move is into the pressed level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable    <= REL_LVL;
      cnt       <= '0;
      key_pulse <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      if (key_sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable    <= key_sync;
        cnt       <= '0;
        key_pulse <= (key_sync == PRESS_LVL);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef KEY_DEBOUNCE_LEVEL_EN
  assign key_level = (stable == PRESS_LVL);
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Randomised scoreboard bench for key_debounce (CNT_MAX=8, active-low key).
// A reference model predicts the edge of every press pulse. A monitor matches each observed
// pulse against those predictions.
// Define KEY_DEBOUNCE_LEVEL_EN to also check key_level on every cycle.
module tb_key_debounce;

  localparam int   CNT    = 8;
  localparam logic REL_K  = 1'b1;
  localparam logic PRS_K  = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key = 1'b0;
  logic key_pulse;
`ifdef KEY_DEBOUNCE_LEVEL_EN
  logic key_level;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state
  logic hist[$];
  int   run = 0;
  logic prev_used = REL_K;
  logic m_stable = REL_K;
  logic m_level = 1'b0;
  int   edge_cnt = 0;
  int   model_presses = 0;
  int   exp_q[$];

  // monitor state
  int   dut_pulses = 0;
  int   ui_counter = 0;
  bit   count_en = 1'b0;

  key_debounce #(
    .CNT_MAX       (CNT),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .key_pulse(key_pulse)
`ifdef KEY_DEBOUNCE_LEVEL_EN
    ,
    .key_level(key_level)
`endif
  );

  always #5 clk = ~clk;

  // Reference model. The filter only looks at the key as sampled two edges earlier. A new level
  // is accepted once that delayed key has held one level for CNT consecutive edges while
  // differing from the accepted level. A move into "pressed" predicts a pulse on that edge.
  always @(posedge clk) begin
    logic used;
    edge_cnt++;
    if (!rst) begin
      hist.delete();
      hist.push_back(REL_K);
      hist.push_back(REL_K);
      run       = 0;
      prev_used = REL_K;
      m_stable  = REL_K;
    end else begin
      hist.push_back(key);
      used = hist[0];
      void'(hist.pop_front());
      if (used == prev_used) run++;
      else begin
        run       = 1;
        prev_used = used;
      end
      if (used != m_stable && run >= CNT) begin
        m_stable = used;
        if (used == PRS_K) begin
          exp_q.push_back(edge_cnt);
          model_presses++;
        end
      end
    end
    m_level = (m_stable == PRS_K);
  end

  // Monitor: match every observed pulse with the oldest prediction, and flag predictions whose
  // edge has passed without a pulse.
  always @(negedge clk) begin
    int e;
    while (exp_q.size() > 0 && exp_q[0] < edge_cnt) begin
      total++;
      bad++;
      $display("[TB] FAIL missed_pulse: expected at edge %0d, no pulse by edge %0d",
               exp_q[0], edge_cnt);
      void'(exp_q.pop_front());
    end
    if (key_pulse === 1'b1) begin
      dut_pulses++;
      if (count_en) ui_counter = (ui_counter == 19) ? 0 : ui_counter + 1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_pulse: pulse at edge %0d, none expected", edge_cnt);
      end else begin
        e = exp_q.pop_front();
        if (e != edge_cnt) begin
          bad++;
          $display("[TB] FAIL pulse_timing: pulse at edge %0d, expected edge %0d", edge_cnt, e);
        end
      end
    end
`ifdef KEY_DEBOUNCE_LEVEL_EN
    if (rst) begin
      total++;
      if (key_level !== m_level) begin
        bad++;
        $display("[TB] FAIL key_level: got %b, expected %b at edge %0d",
                 key_level, m_level, edge_cnt);
      end
    end
`endif
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive a key level at the current falling edge and hold it for n cycles.
  task automatic applyStimulus(input logic lvl, input int n);
    key = lvl;
    repeat (n) @(negedge clk);
  endtask

  // Bounce a few times around lvl, then settle there long enough to be accepted.
  task automatic applyPress(input logic lvl);
    int glitches;
    glitches = $urandom_range(0, 3);
    for (int g = 0; g < glitches; g++) begin
      applyStimulus(lvl, $urandom_range(1, CNT - 1));
      applyStimulus(~lvl, $urandom_range(1, 3));
    end
    applyStimulus(lvl, $urandom_range(CNT + 3, CNT + 12));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // reset state
    rst = 1'b0;
    key = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_pulse", int'(key_pulse), 0);
    checkOutput("reset_cnt", int'(dut.cnt), 0);
    rst = 1'b1;
    applyStimulus(REL_K, 50);
    checkOutput("idle_no_pulse", dut_pulses, 0);

    // clean press, held
    applyStimulus(PRS_K, 40);
    checkOutput("clean_press_count", dut_pulses, 1);
    checkOutput("clean_press_model", dut_pulses, model_presses);

    // release, then bounce that never settles
    applyStimulus(REL_K, 20);
    applyStimulus(PRS_K, 5);
    applyStimulus(REL_K, 2);
    applyStimulus(PRS_K, 6);
    applyStimulus(REL_K, 20);
    checkOutput("bounce_no_pulse", dut_pulses, 1);
    applyStimulus(PRS_K, 12);
    checkOutput("bounce_then_press", dut_pulses, 2);

    // release and re-press
    applyStimulus(REL_K, 20);
    checkOutput("release_no_pulse", dut_pulses, 2);
    applyStimulus(PRS_K, 20);
    checkOutput("repress_count", dut_pulses, 3);

    // reset in the middle of a debounce, key stays held
    applyStimulus(REL_K, 20);
    applyStimulus(PRS_K, 4);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_cnt", int'(dut.cnt), 0);
    rst = 1'b1;
    applyStimulus(PRS_K, 8);
    checkOutput("midreset_early", dut_pulses, 3);
    applyStimulus(PRS_K, 12);
    checkOutput("midreset_press", dut_pulses, 4);
    applyStimulus(REL_K, 20);

    // 20 bouncy presses into a mod-20 counter
    count_en = 1'b1;
    for (int p = 0; p < 20; p++) begin
      applyPress(PRS_K);
      applyPress(REL_K);
      if (p == 18) checkOutput("ui_counter_19", ui_counter, 19);
    end
    checkOutput("ui_counter_wrap", ui_counter, 0);
    checkOutput("twenty_presses", dut_pulses, 24);
    count_en = 1'b0;

    // free-running random key activity against the model
    for (int s = 0; s < 200; s++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    applyStimulus(REL_K, 30);

    checkOutput("final_count", dut_pulses, model_presses);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
